// File: rtl/inst_rom_resp_if.sv
// Fetch and boot-load signal bundle of the instruction-memory responder.
// slave is the responder side; master is the core / loader side.
interface inst_rom_resp_if #(
  parameter int ADDR_W = 10
);
  logic              rom_ce_i;
  logic [31:0]       rom_addr_i;
  logic [31:0]       rom_data_o;
  logic              stallreq_o;
  logic              ld_start_i;
  logic [ADDR_W:0]   ld_len_i;
  logic              ld_valid_i;
  logic [31:0]       ld_data_i;
  logic              ld_ready_o;
  logic              ld_done_o;
  logic              err_o;

  modport slave (
    input  rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_data_i,
    output rom_data_o, stallreq_o, ld_ready_o, ld_done_o, err_o
  );

  modport master (
    output rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_data_i,
    input  rom_data_o, stallreq_o, ld_ready_o, ld_done_o, err_o
  );
endinterface

// File: rtl/inst_rom_resp.sv
// Instruction store with same-cycle fetch, a valid/ready boot-load stream and fetch stall
// on not-yet-loaded words. Define INST_ROM_BYTESWAP_EN to byte-reverse load words.
module inst_rom_resp #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  inst_rom_resp_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt_inc;
  logic              done_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH];

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              aligned;
  logic              loaded;
  logic              fetch_ok;
  logic              accept;
  logic              start;
  logic [31:0]       wr_data;

  // Index math uses the full 32-bit offset so addresses below BASE_ADDR wrap to out of range.
  assign off      = bus.rom_addr_i - BASE_ADDR;
  assign idx      = off[ADDR_W+1:2];
  assign in_range = ((off >> (ADDR_W + 2)) == 32'd0);
  assign aligned  = (bus.rom_addr_i[1:0] == 2'b00);
  assign loaded   = ({1'b0, idx} < cnt);
  assign fetch_ok = in_range & aligned & loaded;

  assign accept   = (state == ST_LOAD) & bus.ld_valid_i;
  assign start    = bus.ld_start_i & (state != ST_LOAD);
  assign cnt_inc  = cnt + 1'b1;

`ifdef INST_ROM_BYTESWAP_EN
  assign wr_data = {bus.ld_data_i[7:0], bus.ld_data_i[15:8],
                    bus.ld_data_i[23:16], bus.ld_data_i[31:24]};
`else
  assign wr_data = bus.ld_data_i;
`endif

  // Unloaded words read as 0, a MIPS nop, so a fetch that races the load is harmless.
  assign bus.rom_data_o = (bus.rom_ce_i & fetch_ok) ? mem[idx] : 32'd0;
  assign bus.stallreq_o = bus.rom_ce_i & (state == ST_LOAD) & in_range & aligned & ~loaded;
  assign bus.ld_ready_o = (state == ST_LOAD);
  assign bus.ld_done_o  = done_q;
  assign bus.err_o      = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      len    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        len   <= bus.ld_len_i;
        cnt   <= '0;
        err_q <= 1'b0;
        if (bus.ld_len_i == '0) begin
          state  <= ST_RUN;
          done_q <= 1'b1;
        end else begin
          state <= ST_LOAD;
        end
      end else begin
        if (bus.rom_ce_i & ~fetch_ok & (state != ST_LOAD))
          err_q <= 1'b1;
        if (accept) begin
          cnt <= cnt_inc;
          if (cnt_inc == len) begin
            state  <= ST_RUN;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the store is deliberately not reset; cnt gates every read, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept)
      mem[cnt[ADDR_W-1:0]] <= wr_data;
  end
endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
- Instruction-memory responder on the core's fetch port: takes rom_ce/rom_addr from pc_reg and returns rom_data in the same cycle.
- Owns a word-addressed instruction store that is filled at boot through a valid/ready load stream.
- Raises a stall request when the core fetches a word that has not been loaded yet. This lets instruction fetch overlap the program load.

Parameters:
- ADDR_W, 10, word-address width; store depth = 2**ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to store word 0.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rom_ce_i  input  1  fetch enable from the core
- rom_addr_i  input  32  fetch byte address
- rom_data_o  output  32  fetched instruction (combinational)
- stallreq_o  output  1  request to the core's ctrl to freeze fetch (combinational)
- ld_start_i  input  1  start a load session
- ld_len_i  input  ADDR_W+1  number of words to load, 0..2**ADDR_W
- ld_valid_i  input  1  load word valid
- ld_data_i  input  32  load word
- ld_ready_o  output  1  responder accepts a load word
- ld_done_o  output  1  one-cycle pulse when the load completes
- err_o  output  1  sticky fetch-error flag

Behaviour:
- Reset: state=IDLE; load count cnt=0; latched length len=0; ld_ready_o=0; ld_done_o=0; err_o=0. The storage array is not reset. With cnt=0 every fetch reads 0.
- Fetch index: idx = (rom_addr_i - BASE_ADDR) >> 2, 32-bit unsigned subtraction.
  - Out of range: idx >= 2**ADDR_W.
  - Misaligned: rom_addr_i[1:0] != 0.
- States:
  - IDLE: ld_start_i=1 latches len=ld_len_i and sets cnt=0, err_o=0. Next state is LOAD, or RUN if ld_len_i=0 (ld_done_o pulses in that case as well).
  - LOAD: ld_ready_o=1. On ld_valid_i & ld_ready_o, write mem[cnt]=ld_data_i and cnt=cnt+1. When the accepted word makes cnt==len, go to RUN and pulse ld_done_o on the next cycle. ld_start_i is ignored in LOAD.
  - RUN: ld_ready_o=0. ld_start_i=1 restarts as in IDLE (reload); cnt=0 takes effect on the next cycle.
- rom_data_o:
  - 0 when rom_ce_i=0, or the address is misaligned/out of range, or idx >= cnt.
  - Otherwise mem[idx].
  - 0 is a MIPS nop, so these cases are safe for the core.
- stallreq_o = rom_ce_i & (state==LOAD) & in-range & aligned & (idx >= cnt).
  - A fetch to the word being written this cycle still stalls; the data is valid the next cycle, once cnt has advanced.
- err_o: set on any rising edge where rom_ce_i=1 and state!=LOAD and (misaligned, or out of range, or idx >= cnt). It holds until the next ld_start_i or rst.
- Asserting rst mid-load aborts the session: cnt=0, state=IDLE, and the next cycle's fetches read 0.
- Full: after 2**ADDR_W accepts, cnt = 2**ADDR_W. cnt has no wrap-around.

Optional Feature:
- INST_ROM_BYTESWAP_EN
  - Defined: each load word is byte-reversed before it is written (big-endian load stream), i.e. mem gets {d[7:0],d[15:8],d[23:16],d[31:24]}.
  - Undefined: words are stored exactly as received.
  - Fetch path is unchanged in both cases.

Test Plan:
1. Reset, then rom_ce_i=1, rom_addr_i=0 -> rom_data_o=0, stallreq_o=0, ld_ready_o=0. Next edge -> err_o=1.
2. ld_start_i with ld_len_i=3, then stream 0x34011100, 0x34020020, 0x3403FF00 back-to-back -> ld_ready_o=1 for 3 cycles, ld_done_o pulses once, state RUN. Fetch addr 8 -> 0x3403FF00.
3. During a load with len=4 and 1 word loaded, fetch addr 4 -> stallreq_o=1, rom_data_o=0. Send word 2 = 0x00000020 -> next cycle stallreq_o=0, rom_data_o=0x00000020.
4. In RUN with len=3, fetch addr 12 or addr 2 -> rom_data_o=0, stallreq_o=0, err_o=1. Then ld_start_i -> err_o=0.
5. Assert rst after 2 of 4 words are accepted -> ld_ready_o=0, fetch addr 0 returns 0, ld_done_o never pulses.
6. With INST_ROM_BYTESWAP_EN defined, load 0x11223344 -> fetch addr 0 returns 0x44332211. Without it -> returns 0x11223344.
